itof_pipe: RTL
==============

# itof_pipe

Parametrised, pipelined integer-to-single-precision converter with valid/ready handshaking, signed/unsigned mode select and IEEE-754 round-to-nearest-even. It is the next-generation replacement for the fixed 32-bit, always-valid itof unit. It sits in the FPU issue path between the integer register read and the FP writeback arbiter. Back-pressure from writeback stalls the whole pipeline without losing or duplicating results.

## Interface
- WIDTH, 32, integer operand width; legal range 8..64.
- NSTAGE, 2, pipeline depth (input-to-output latency in cycles); legal range 1..3.
- clk  in  1  clock; all state updates on its rising edge.
- rstn  in  1  asynchronous active-low reset.
- in_valid  in  1  operand offered this cycle.
- in_ready  out  1  pipeline accepts an operand this cycle.
- in_data  in  WIDTH  integer operand.
- in_unsigned  in  1  1 = treat in_data as unsigned, 0 = two's-complement; sampled with in_data.
- out_valid  out  1  result available.
- out_ready  in  1  consumer takes the result this cycle.
- out_data  out  32  IEEE-754 single result.
- out_inexact  out  1  result was rounded (discarded bits nonzero).

## Operation
- Transfer rules: input accepted when in_valid && in_ready; output consumed when out_valid && out_ready.
- Global advance enable en = out_ready || !out_valid. in_ready = en.
- When en=0, every stage register holds, including its valid bit.
- Bubbles travel with valid=0. They do not collapse while en=1.
- Conversion, signed mode: sign = in_data[WIDTH-1]; magnitude = two's-complement absolute value, held in WIDTH bits as unsigned. The most negative value therefore has magnitude 2^(WIDTH-1).
- Conversion, unsigned mode: sign = 0; magnitude = in_data.
- Zero magnitude gives out_data = 0x00000000 and inexact = 0. -0.0 is never produced.
- Otherwise, p = index of the leading one (via leading-zero count).
  - Exponent = 127 + p.
  - Normalise so the leading one is implicit and take 23 mantissa bits.
  - Guard = next bit below the mantissa; sticky = OR of all lower bits.
- Rounding is RNE: increment when guard && (sticky || mantissa LSB).
  - If the mantissa carry overflows, mantissa = 0 and exponent + 1.
  - inexact = guard || sticky.
- When p ≤ 23 the result is exact and no rounding occurs.
- WIDTH ≤ 64 means the exponent is at most 191. Overflow to infinity and denormals cannot occur.
- Stage split:
  - NSTAGE=1: everything in one registered stage.
  - NSTAGE=2: stage 1 = abs + LZC; stage 2 = shift + round.
  - NSTAGE=3: stage 1 = abs + LZC; stage 2 = shift; stage 3 = round + pack.

## Timing
- Latency: exactly NSTAGE cycles from the accept edge to out_valid, with no stall.
- Throughput: one result per cycle while out_ready=1.
- Stall: out_valid=1 && out_ready=0 freezes all stages. out_data and out_inexact stay stable until consumed.
- Simultaneous consume and accept in one cycle is legal and required for full throughput.
- Reset values (asynchronous, immediate): out_valid=0, out_data=0, out_inexact=0, all internal valid bits 0. in_ready=1 while rstn=0 and afterwards.
- Reset mid-operation discards all in-flight operands; no partial result appears after release.
- The first acceptance is possible on the first rising edge after rstn deasserts.

## Structure
- Package itof_pkg holds:
  - FP32_BIAS=127, FP32_MANT_W=23, FP32_EXP_W=8.
  - fp32_t packed struct {sign, exp[7:0], mant[22:0]}.
  - A stage-payload struct parametrised by width via a localparam in the module.
- Sub-module itof_lzc: parametrised leading-zero counter (WIDTH in, $clog2(WIDTH)+1 out, all-zero flag), purely combinational.
- The stage registers and the enable/valid chain live in itof_pipe.

## Test plan
- WIDTH=32, signed: inputs 1, -1, 0 -> 0x3F800000, 0xBF800000, 0x00000000; inexact=0 for all; each appears exactly NSTAGE cycles after accept.
- Rounding: 0x01000001 -> 0x4B800000 (tie to even, inexact=1); 0x01000003 -> 0x4B800002 (tie rounds up, inexact=1); 0x7FFFFFFF -> 0x4F000000 (carry into exponent).
- Mode: 0xFFFFFFFF unsigned -> 0x4F800000; same word signed -> 0xBF800000; 0x80000000 signed -> 0xCF000000.
- Back-pressure: stream 8 operands and hold out_ready=0 for 5 cycles mid-stream -> in_ready=0 while out_valid=1; outputs hold stable; all 8 results arrive in order with no loss or duplication.
- Reset mid-stream: assert rstn=0 with 2 operands in flight -> out_valid drops immediately; after release no stale result appears; a new operand gives its correct result after NSTAGE cycles.
- Parameter sweep: WIDTH ∈ {8,32,64} × NSTAGE ∈ {1,2,3}, 10^6 random operands with random handshake gaps, each result compared bit-exactly against the simulator's shortreal conversion of $itor(magnitude) with the sign applied, including the inexact flag.

Source files
------------

// File: rtl/itof_pkg.sv
// Shared constants and types for the integer-to-float pipeline.
//   FP32_BIAS / FP32_MANT_W / FP32_EXP_W : IEEE-754 single-precision field geometry
//   fp32_t                               : packed single-precision word {sign, exp, mant}
package itof_pkg;

  localparam int FP32_BIAS   = 127;
  localparam int FP32_MANT_W = 23;
  localparam int FP32_EXP_W  = 8;

  typedef struct packed {
    logic                   sign;
    logic [FP32_EXP_W-1:0]  exp;
    logic [FP32_MANT_W-1:0] mant;
  } fp32_t;

  // Packs a non-zero rounded result; a zero operand always maps to +0.0.
  function automatic fp32_t fp32_pack(input logic                   zero,
                                      input logic                   sign,
                                      input logic [FP32_EXP_W-1:0]  exp,
                                      input logic [FP32_MANT_W-1:0] mant);
    fp32_t r;
    r = '0;
    if (!zero) begin
      r.sign = sign;
      r.exp  = exp;
      r.mant = mant;
    end
    return r;
  endfunction

endpackage

// File: rtl/itof_lzc.sv
// Combinational leading-zero counter.
//   data     : operand
//   count    : number of leading zeros (WIDTH when data is zero)
//   all_zero : data == 0
module itof_lzc #(
  parameter int unsigned WIDTH = 32,
  localparam int unsigned CW   = $clog2(WIDTH) + 1
) (
  input  logic [WIDTH-1:0] data,
  output logic [CW-1:0]    count,
  output logic             all_zero
);

  always_comb begin
    count = CW'(WIDTH);
    // Scanning upward, the last set bit seen is the leading one.
    for (int i = 0; i < int'(WIDTH); i++) begin
      if (data[i]) begin
        count = CW'(int'(WIDTH) - 1 - i);
      end
    end
  end

  assign all_zero = ~|data;

endmodule

// File: rtl/itof_pipe.sv
// Pipelined integer to IEEE-754 single converter, round-to-nearest-even, valid/ready.
//   clk, rstn              : clock, asynchronous active-low reset
//   in_valid / in_ready    : operand handshake
//   in_data, in_unsigned   : operand and its interpretation (1 = unsigned)
//   out_valid / out_ready  : result handshake
//   out_data, out_inexact  : single-precision result and rounding flag
// Work is split into three phases (abs+LZC, shift, round+pack); NSTAGE chooses
// where registers sit between them. All stages advance together on en.
module itof_pipe
  import itof_pkg::*;
#(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned NSTAGE = 2
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_unsigned,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data,
  output logic             out_inexact
);

  localparam int unsigned LZW = $clog2(WIDTH) + 1;

  typedef struct packed {
    logic             sign;
    logic             zero;
    logic [WIDTH-1:0] mag;
    logic [LZW-1:0]   lzc;
  } abs_pay_t;

  typedef struct packed {
    logic                   sign;
    logic                   zero;
    logic [FP32_EXP_W-1:0]  exp;
    logic [FP32_MANT_W-1:0] mant;
    logic                   guard;
    logic                   sticky;
  } norm_pay_t;

  logic en;
  assign en       = out_ready | ~out_valid;
  assign in_ready = en;

  // Phase A: sign / magnitude and leading-zero count.
  logic             a_sign;
  logic [WIDTH-1:0] a_mag;
  logic [LZW-1:0]   a_lzc;
  logic             a_zero;
  abs_pay_t         a_pay;

  assign a_sign = ~in_unsigned & in_data[WIDTH-1];
  // The most negative value negates to itself, which read unsigned is 2^(WIDTH-1).
  assign a_mag  = a_sign ? (~in_data + WIDTH'(1)) : in_data;

  itof_lzc #(
    .WIDTH (WIDTH)
  ) u_lzc (
    .data     (a_mag),
    .count    (a_lzc),
    .all_zero (a_zero)
  );

  always_comb begin
    a_pay      = '0;
    a_pay.sign = a_sign;
    a_pay.zero = a_zero;
    a_pay.mag  = a_mag;
    a_pay.lzc  = a_lzc;
  end

  // Phase B: normalise, extract mantissa, guard and sticky.
  abs_pay_t              b_src;
  norm_pay_t             b_pay;
  logic [LZW:0]          b_shamt;
  logic [WIDTH-1:0]      b_frac;
  logic [WIDTH+23:0]     b_fx;

  always_comb begin
    // Shifting one past the leading one leaves only the fraction bits.
    b_shamt      = {1'b0, b_src.lzc} + (LZW+1)'(1);
    b_frac       = b_src.mag << b_shamt;
    b_fx         = {b_frac, 24'b0};
    b_pay        = '0;
    b_pay.sign   = b_src.sign;
    b_pay.zero   = b_src.zero;
    b_pay.exp    = FP32_EXP_W'(FP32_BIAS + int'(WIDTH) - 1) - FP32_EXP_W'(b_src.lzc);
    b_pay.mant   = b_fx[WIDTH+23 -: FP32_MANT_W];
    b_pay.guard  = b_fx[WIDTH];
    b_pay.sticky = |b_fx[WIDTH-1:0];
  end

  // Phase C: round-to-nearest-even and pack.
  norm_pay_t              c_src;
  logic                   c_inc;
  logic [FP32_MANT_W:0]   c_sum;
  logic [FP32_EXP_W-1:0]  c_exp;
  fp32_t                  c_res;
  logic                   c_inexact;

  always_comb begin
    c_inc     = c_src.guard & (c_src.sticky | c_src.mant[0]);
    c_sum     = {1'b0, c_src.mant} + (FP32_MANT_W+1)'(c_inc);
    // A carry out of the mantissa leaves it all-zero and bumps the exponent.
    c_exp     = c_src.exp + FP32_EXP_W'(c_sum[FP32_MANT_W]);
    c_res     = fp32_pack(c_src.zero, c_src.sign, c_exp, c_sum[FP32_MANT_W-1:0]);
    c_inexact = ~c_src.zero & (c_src.guard | c_src.sticky);
  end

  // Stage registers between phases, present only when the depth calls for them.
  if (NSTAGE >= 2) begin : g_s1
    abs_pay_t s1_q;
    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        s1_q <= '0;
      end else if (en) begin
        s1_q <= a_pay;
      end
    end
    assign b_src = s1_q;
  end else begin : g_no_s1
    assign b_src = a_pay;
  end

  if (NSTAGE >= 3) begin : g_s2
    norm_pay_t s2_q;
    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        s2_q <= '0;
      end else if (en) begin
        s2_q <= b_pay;
      end
    end
    assign c_src = s2_q;
  end else begin : g_no_s2
    assign c_src = b_pay;
  end

  // Output register and valid chain; bubbles shift through as valid=0.
  fp32_t             out_q;
  logic              inexact_q;
  logic [NSTAGE-1:0] vld_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      out_q     <= '0;
      inexact_q <= 1'b0;
      vld_q     <= '0;
    end else if (en) begin
      out_q     <= c_res;
      inexact_q <= c_inexact;
      vld_q[0]  <= in_valid;
      for (int i = 1; i < int'(NSTAGE); i++) begin
        vld_q[i] <= vld_q[i-1];
      end
    end
  end

  assign out_valid   = vld_q[NSTAGE-1];
  assign out_data    = out_q;
  assign out_inexact = inexact_q;

endmodule
